// File: rtl/branch_predictor.sv
// branch_predictor: one-cycle bimodal predictor with saturating counters and PC+imm target.
// Define BPU_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CNT_BITS = 2,
  parameter int GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic [XLEN-1:0] lookup_imm,
  input  logic            lookup_is_branch,
  input  logic            lookup_is_jump,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d [ENTRIES];
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
`ifdef BPU_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  assign lk_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign up_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  always_comb ghr_d = upd_valid ? GHR_BITS'({ghr_q, upd_taken}) : ghr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ghr_q <= '0;
    else ghr_q <= ghr_d;
`else
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
`endif
  // Prediction reads cnt_q, so a same-cycle update to the same entry is not yet visible.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_valid)
      cnt_d[up_idx] = upd_taken ? (cnt_q[up_idx] == CNT_MAX ? CNT_MAX : cnt_q[up_idx] + 1'b1)
                                : (cnt_q[up_idx] == '0 ? '0 : cnt_q[up_idx] - 1'b1);
    pred_valid_d  = lookup_valid & ~flush;
    pred_taken_d  = pred_valid_d & (lookup_is_jump | (lookup_is_branch & cnt_q[lk_idx][CNT_BITS-1]));
    pred_target_d = (pred_valid_d & (lookup_is_jump | lookup_is_branch)) ? lookup_pc + lookup_imm : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      cnt_q         <= cnt_d;
    end
  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
endmodule
